fetch_unit: RTL and testbench

Instruction-fetch stage of the five-stage pipeline. Owns the program counter, issues requests to the instruction memory over a valid/ready request channel and a fixed-width response channel, and drives the F/D pipeline register consumed by the decode stage (`D_ins`, `D_PC`). It honours the hazard-unit stall, and it accepts branch/jump redirects from decode (`PCw_enable`, `DnPC`) with MIPS single-delay-slot semantics.

---
 rtl/cpu_pkg.sv | 6 +
 rtl/fd_pipe_reg.sv | 29 ++
 rtl/fetch_unit.sv | 72 +++++++
 tb/tb_fetch_unit.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// cpu_pkg: shared pipeline constants and the fetch FSM state encoding.
package cpu_pkg;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_3000;
  localparam logic [31:0] NOP = 32'h0000_0000;
  typedef enum logic [1:0] {ISSUE = 2'd0, WAIT = 2'd1, HOLD = 2'd2} fetch_state_t;
endpackage

// File: rtl/fd_pipe_reg.sv
// fd_pipe_reg: F/D pipeline register; holds on stall, loads on load, otherwise inserts a bubble.
module fd_pipe_reg (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        load,
  input  logic [31:0] ins,
  input  logic [31:0] pc,
  input  logic        adel,
  output logic [31:0] D_ins,
  output logic [31:0] D_PC,
  output logic        D_valid,
  output logic        D_adel
);
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      D_ins <= '0;
      D_PC <= '0;
      D_valid <= 1'b0;
      D_adel <= 1'b0;
    end else if (!stall) begin
      if (load) begin
        D_ins <= ins;
        D_PC <= pc;
      end
      D_valid <= load;
      D_adel <= load & adel;
    end
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: IF stage owning the PC, one outstanding imem request, delay-slot redirects, F/D register.
// Define FETCH_ADEL_EN to report misaligned fetch addresses on D_adel instead of aligning im_addr.
module fetch_unit import cpu_pkg::*; #(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        PCw_enable,
  input  logic [31:0] DnPC,
  output logic        im_req_valid,
  input  logic        im_req_ready,
  output logic [31:0] im_addr,
  input  logic        im_rsp_valid,
  input  logic [31:0] im_rsp_data,
  output logic [31:0] D_ins,
  output logic [31:0] D_PC,
  output logic        D_valid,
  output logic        D_adel
);
  fetch_state_t state;
  logic [31:0] f_pc, redir_tgt, hold_data, next_pc, ld_ins;
  logic redir_pend, live, misal, rsp_ld, hold_ld, adel_ld, load, cap;
`ifdef FETCH_ADEL_EN
  assign misal = |f_pc[1:0];
  assign im_addr = f_pc;
`else
  assign misal = 1'b0;
  assign im_addr = {f_pc[31:2], 2'b00};
`endif
  // live keeps the request low for the first cycle out of reset
  assign im_req_valid = live && state == ISSUE && !misal;
  assign rsp_ld = state == WAIT && im_rsp_valid && !stall;
  assign hold_ld = state == HOLD && !stall;
  assign adel_ld = state == ISSUE && misal && !stall;
  assign load = rsp_ld || hold_ld || adel_ld;
  assign cap = !stall && PCw_enable;
  // a redirect arriving with the delay-slot load steers the PC straight to DnPC
  assign next_pc = cap ? DnPC : redir_pend ? redir_tgt : f_pc + 32'd4;
  assign ld_ins = adel_ld ? NOP : hold_ld ? hold_data : im_rsp_data;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state <= ISSUE;
      f_pc <= RESET_PC;
      redir_pend <= 1'b0;
      redir_tgt <= '0;
      hold_data <= NOP;
      live <= 1'b0;
    end else begin
      live <= 1'b1;
      state <= (im_req_valid && im_req_ready) ? WAIT
             : (state == WAIT && im_rsp_valid) ? (stall ? HOLD : ISSUE)
             : hold_ld ? ISSUE : state;
      if (load) f_pc <= next_pc;
      redir_pend <= !load && (redir_pend || cap);
      if (cap) redir_tgt <= DnPC;
      if (state == WAIT && im_rsp_valid && stall) hold_data <= im_rsp_data;
    end
  fd_pipe_reg u_fd (
    .clk(clk),
    .reset(reset),
    .stall(stall),
    .load(load),
    .ins(ld_ins),
    .pc(f_pc),
    .adel(adel_ld),
    .D_ins(D_ins),
    .D_PC(D_PC),
    .D_valid(D_valid),
    .D_adel(D_adel)
  );
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed + randomized bench; the model tracks program-order fetch addresses and F/D contents.
module tb_fetch_unit;
  localparam logic [31:0] RPC = 32'h0000_3000;
  logic clk = 0, reset = 1, stall = 0, PCw_enable = 0, im_req_ready = 0, im_rsp_valid = 0;
  logic [31:0] DnPC = 0, im_rsp_data = 0;
  logic im_req_valid, D_valid, D_adel;
  logic [31:0] im_addr, D_ins, D_PC;
  int checks = 0, errors = 0;

  fetch_unit #(.RESET_PC(RPC)) dut (
    .clk(clk), .reset(reset), .stall(stall), .PCw_enable(PCw_enable), .DnPC(DnPC),
    .im_req_valid(im_req_valid), .im_req_ready(im_req_ready), .im_addr(im_addr),
    .im_rsp_valid(im_rsp_valid), .im_rsp_data(im_rsp_data),
    .D_ins(D_ins), .D_PC(D_PC), .D_valid(D_valid), .D_adel(D_adel)
  );

  always #5 clk = ~clk;

  int p_stall, p_ready, p_pcw, max_dly, n_req, n_del, mem_cnt, since_rst, tot;
  logic late, ov, outst, got, e_valid, e_adel, exp_req, seen;
  logic [31:0] next_exp, ov_t, e_ins, e_pc, hold_pc, a;
  logic [31:0] q_addr[$];
  logic s_req, s_ready, s_stall, s_rsp, s_pcw;
  logic [31:0] s_dnpc;

  function automatic logic [31:0] mem(input logic [31:0] x);
    return x ^ 32'h5A5A_0F0F;
  endfunction

  function automatic logic [31:0] bus(input logic [31:0] x);
`ifdef FETCH_ADEL_EN
    return x;
`else
    return {x[31:2], 2'b00};
`endif
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic checkb(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    next_exp = RPC; ov = 0; ov_t = 0; outst = 0; got = 0; n_req = 0; n_del = 0;
    mem_cnt = 0; since_rst = 0; q_addr.delete();
    e_ins = 0; e_pc = 0; e_valid = 0; e_adel = 0;
  endtask

  task automatic drive();
    stall = $urandom_range(99) < p_stall;
    im_req_ready = $urandom_range(99) < p_ready;
    PCw_enable = $urandom_range(99) < p_pcw;
    DnPC = ($urandom_range(9) == 0) ? 32'hFFFF_FFF8 : RPC + ($urandom_range(255) << 2);
    im_rsp_valid = 0;
    if (mem_cnt > 0) begin
      mem_cnt--;
      if (mem_cnt == 0 && q_addr.size() > 0) begin
        im_rsp_valid = 1;
        im_rsp_data = mem(bus(q_addr[0]));
      end
    end
    if (late) begin
      im_rsp_valid = 1;
      im_rsp_data = 32'hDEAD_BEEF;
      late = 0;
    end
    s_req = im_req_valid; s_ready = im_req_ready; s_stall = stall;
    s_rsp = im_rsp_valid; s_pcw = PCw_enable; s_dnpc = DnPC;
  endtask

  task automatic apply();
    stall = p_stall >= 100; im_req_ready = p_ready >= 100;
    s_stall = stall; s_ready = im_req_ready;
  endtask

  task automatic redirect(input logic [31:0] t);
    PCw_enable = 1; DnPC = t; s_pcw = 1; s_dnpc = t;
  endtask

  // advance one clock, update the model from the pre-edge inputs, compare, drive the next cycle
  task automatic step();
    int k;
    logic ld;
    @(posedge clk);
    #1;
    k = n_del; ld = 0; since_rst++;
    if (s_req && s_ready) begin
      q_addr.push_back(next_exp);
      next_exp = ov ? ov_t : next_exp + 32'd4;
      ov = 0; n_req++; outst = 1;
      mem_cnt = $urandom_range(max_dly, 1);
    end
    if (s_rsp && outst) begin outst = 0; got = 1; end
    if (!s_stall && got) begin
      ld = 1; got = 0; n_del++; tot++;
      e_pc = q_addr.pop_front(); e_ins = mem(bus(e_pc)); e_adel = 0;
    end
`ifdef FETCH_ADEL_EN
    else if (!s_stall && !outst && next_exp[1:0] != 2'b00) begin
      ld = 1; n_del++; n_req++; tot++;
      e_pc = next_exp; e_ins = 0; e_adel = 1;
      next_exp = ov ? ov_t : next_exp + 32'd4;
      ov = 0;
    end
`endif
    if (!s_stall) begin
      e_valid = ld;
      if (!ld) e_adel = 0;
    end
    // the fetch after the in-flight one (index k) goes to the target
    if (s_pcw && !s_stall) begin
      if (n_req == k + 1) next_exp = s_dnpc;
      else begin ov = 1; ov_t = s_dnpc; end
    end
    checkb("D_valid", D_valid, e_valid);
    check("D_PC", D_PC, e_pc);
    check("D_ins", D_ins, e_ins);
    checkb("D_adel", D_adel, e_adel);
    exp_req = since_rst >= 1 && !outst && !got;
`ifdef FETCH_ADEL_EN
    exp_req = exp_req && next_exp[1:0] == 2'b00;
`endif
    checkb("req_valid", im_req_valid, exp_req);
    if (exp_req) check("im_addr", im_addr, bus(next_exp));
    drive();
  endtask

  task automatic do_reset();
    reset = 0;
    im_rsp_valid = 1;
    #1;
    checkb("rst_D_valid", D_valid, 0);
    check("rst_D_PC", D_PC, 0);
    check("rst_D_ins", D_ins, 0);
    checkb("rst_D_adel", D_adel, 0);
    checkb("rst_req_valid", im_req_valid, 0);
    check("rst_im_addr", im_addr, RPC);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1;
    late = 1;
    model_reset();
    drive();
  endtask

  initial begin
    p_stall = 0; p_ready = 100; p_pcw = 0; max_dly = 1; late = 0; tot = 0;
    model_reset();
    #2 do_reset();
    repeat (2) begin step(); checkb("early_D_valid", D_valid, 0); end
    step();
    checkb("first_D_valid", D_valid, 1);
    check("first_D_PC", D_PC, RPC);
    repeat (4) step();
    check("branch_in_D", D_PC, 32'h3008);
    redirect(32'h3100);
    repeat (2) step();
    check("delay_slot_PC", D_PC, 32'h300C);
    check("target_addr", im_addr, 32'h3100);
    step();
    p_stall = 100; apply();
    hold_pc = D_PC;
    repeat (3) begin step(); check("stall_D_PC", D_PC, hold_pc); end
    p_stall = 0; apply();
    step();
    check("hold_deliver_PC", D_PC, 32'h3100);
    checkb("hold_deliver_valid", D_valid, 1);
    p_ready = 0; apply();
    a = im_addr;
    repeat (4) begin
      step();
      check("ready_low_addr", im_addr, a);
      checkb("ready_low_D_valid", D_valid, 0);
    end
    p_ready = 100; apply();
    repeat (2) step();
    check("ready_release_PC", D_PC, a);
    for (int i = 0; i < 20 && !outst; i++) step();
    checkb("reached_wait", outst, 1);
    #2 do_reset();
    step();
    check("post_reset_addr", im_addr, RPC);
    checkb("post_reset_D_valid", D_valid, 0);
    repeat (4) step();
    p_stall = 30; p_ready = 70; p_pcw = 8; max_dly = 3;
    repeat (2000) step();
    p_stall = 0; p_ready = 100; p_pcw = 0; max_dly = 1; apply();
    redirect(32'h3102);
    seen = 0;
    repeat (12) begin
      step();
      if (D_valid && D_PC == 32'h3102) seen = 1;
    end
    checkb("misaligned_target_delivered", seen, 1);
    checkb("progress", tot > 200, 1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
